// File: rtl/da_pkg.sv
// Shared types and default parameters for the da_p2s DAC serializer.
// Pulls in no other package; the optional ldac_n feature is selected with DA_LDAC_EN.
package da_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } da_state_t;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_SCLK_DIV = 4;
    localparam int DEF_CSN_GAP  = 2;

    // Accept-to-accept spacing is one cycle longer than this, because of the IDLE cycle.
    localparam int FRAME_CYC = DEF_SCLK_DIV * (2 * DEF_DATA_W + 2 + DEF_CSN_GAP);

endpackage

// File: rtl/da_sclk_div.sv
// Half-period timer: counts 0..DIV-1 and flags the terminal count.
// A clear restarts the count, so every state begins with a full half-period.
module da_sclk_div
    import da_pkg::*;
#(
    parameter int DIV = DEF_SCLK_DIV
) (
    input  logic clk_sys,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TC = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr || cnt == TC)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == TC);

endmodule

// File: rtl/da_p2s.sv
// Parallel-to-serial DAC driver: one cs_n-framed, MSB-first SPI write per accepted word.
// Optional DA_LDAC_EN adds an ldac_n strobe that goes low with da_done.
//
//   state | meaning
//   IDLE  | da_rdy=1, waiting for da_vld
//   SETUP | cs_n low, sclk high, sdata = MSB
//   SHIFT | DATA_W bits, sclk low then high each bit
//   HOLD  | cs_n low, sclk high, sdata = LSB
//   GAP   | cs_n high, sdata 0, da_done on first cycle
module da_p2s
    import da_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int SCLK_DIV = DEF_SCLK_DIV,
    parameter int CSN_GAP  = DEF_CSN_GAP
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic [DATA_W-1:0] da_data,
    input  logic              da_vld,
    output logic              da_rdy,
    output logic              da_done,
    output logic              cs_n,
    output logic              sclk,
    output logic              sdata
`ifdef DA_LDAC_EN
    ,
    output logic              ldac_n
`endif
);

`ifdef DA_LDAC_EN
    localparam int GAP_HP = (CSN_GAP < 1) ? 1 : CSN_GAP;
`else
    localparam int GAP_HP = CSN_GAP;
`endif
    localparam int BW = $clog2(DATA_W);
    localparam int GW = (GAP_HP > 1) ? $clog2(GAP_HP) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_HP - 1);

    da_state_t         state, state_nxt;
    logic              phase, phase_nxt;
    logic [BW-1:0]     bit_cnt, bit_cnt_nxt;
    logic [GW-1:0]     gap_cnt, gap_cnt_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic              tick, clr, accept, frame_nxt;

    assign accept    = da_vld & da_rdy;
    assign clr       = (state_nxt != state);
    assign frame_nxt = (state_nxt == SETUP) || (state_nxt == SHIFT) || (state_nxt == HOLD);

    da_sclk_div #(.DIV(SCLK_DIV)) u_div (
        .clk_sys (clk_sys),
        .rst     (rst),
        .clr     (clr),
        .tick    (tick)
    );

    always_comb begin
        state_nxt   = state;
        phase_nxt   = phase;
        bit_cnt_nxt = bit_cnt;
        gap_cnt_nxt = gap_cnt;
        shreg_nxt   = shreg;
        case (state)
            IDLE: if (accept) begin
                state_nxt = SETUP;
                shreg_nxt = da_data;
            end
            SETUP: if (tick) begin
                state_nxt   = SHIFT;
                phase_nxt   = 1'b0;
                bit_cnt_nxt = BIT_LAST;
            end
            SHIFT: if (tick) begin
                // phase 0 -> 1 is the sclk rise; the last bit keeps its value into HOLD
                if (!phase) begin
                    phase_nxt = 1'b1;
                    if (bit_cnt != '0)
                        shreg_nxt = {shreg[DATA_W-2:0], 1'b0};
                end else if (bit_cnt == '0) begin
                    state_nxt = HOLD;
                end else begin
                    phase_nxt   = 1'b0;
                    bit_cnt_nxt = bit_cnt - 1'b1;
                end
            end
            HOLD: if (tick) begin
                state_nxt   = GAP;
                gap_cnt_nxt = '0;
            end
            GAP: if (tick) begin
                if (gap_cnt == GAP_LAST)
                    state_nxt = IDLE;
                else
                    gap_cnt_nxt = gap_cnt + 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            phase   <= 1'b0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            shreg   <= '0;
            cs_n    <= 1'b1;
            sclk    <= 1'b1;
            sdata   <= 1'b0;
            da_rdy  <= 1'b0;
            da_done <= 1'b0;
`ifdef DA_LDAC_EN
            ldac_n  <= 1'b1;
`endif
        end else begin
            state   <= state_nxt;
            phase   <= phase_nxt;
            bit_cnt <= bit_cnt_nxt;
            gap_cnt <= gap_cnt_nxt;
            shreg   <= shreg_nxt;
            cs_n    <= !frame_nxt;
            sclk    <= !((state_nxt == SHIFT) && !phase_nxt);
            sdata   <= frame_nxt ? shreg_nxt[DATA_W-1] : 1'b0;
            da_rdy  <= (state_nxt == IDLE);
            da_done <= (state == HOLD) && (state_nxt == GAP);
`ifdef DA_LDAC_EN
            ldac_n  <= !((state_nxt == GAP) && (gap_cnt_nxt == '0));
`endif
        end
    end

endmodule

// File: tb/tb_da_p2s.sv
// Directed bench for da_p2s: a default instance and a DATA_W=8, SCLK_DIV=2 instance.
// Build with DA_LDAC_EN defined to also check the ldac_n strobe.
module tb_da_p2s;

    logic clk_sys = 1'b0;
    logic rst     = 1'b1;
    always #5 clk_sys = ~clk_sys;

    logic [15:0] data_a = '0;
    logic        vld_a  = 1'b0;
    logic        rdy_a, done_a, csn_a, sclk_a, sdata_a;
    logic [7:0]  data_b = '0;
    logic        vld_b  = 1'b0;
    logic        rdy_b, done_b, csn_b, sclk_b, sdata_b;
    logic        ldac_a, ldac_b;

    da_p2s u_a (
        .clk_sys (clk_sys), .rst (rst), .da_data (data_a), .da_vld (vld_a),
        .da_rdy (rdy_a), .da_done (done_a), .cs_n (csn_a), .sclk (sclk_a), .sdata (sdata_a)
`ifdef DA_LDAC_EN
        , .ldac_n (ldac_a)
`endif
    );

    da_p2s #(.DATA_W(8), .SCLK_DIV(2), .CSN_GAP(2)) u_b (
        .clk_sys (clk_sys), .rst (rst), .da_data (data_b), .da_vld (vld_b),
        .da_rdy (rdy_b), .da_done (done_b), .cs_n (csn_b), .sclk (sclk_b), .sdata (sdata_b)
`ifdef DA_LDAC_EN
        , .ldac_n (ldac_b)
`endif
    );

`ifndef DA_LDAC_EN
    assign ldac_a = 1'b1;
    assign ldac_b = 1'b1;
`endif

    int   sel = 0;
    logic m_rdy, m_done, m_csn, m_sclk, m_sdata, m_ldac;
    always_comb begin
        m_rdy   = (sel == 0) ? rdy_a   : rdy_b;
        m_done  = (sel == 0) ? done_a  : done_b;
        m_csn   = (sel == 0) ? csn_a   : csn_b;
        m_sclk  = (sel == 0) ? sclk_a  : sclk_b;
        m_sdata = (sel == 0) ? sdata_a : sdata_b;
        m_ldac  = (sel == 0) ? ldac_a  : ldac_b;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    typedef struct {
        int          s;
        logic [15:0] word;
        logic [15:0] exp_bits;
        int          exp_low;
        int          exp_falls;
        int          exp_ldac;
    } vec_t;

    // One frame on the selected instance; returns what was observed on the pins.
    task automatic run_frame(input int s, input logic [15:0] word,
                             output logic [15:0] bits, output int low, output int falls,
                             output int dones, output int rdy_bad, output int edge_bad,
                             output int ldac_low, output int ldac_bad, output int ok);
        int   n;
        logic p_sclk, p_sdata, p_csn;
        sel = s;
        bits = '0; low = 0; falls = 0; dones = 0; rdy_bad = 0; edge_bad = 0;
        ldac_low = 0; ldac_bad = 0; ok = 0;
        n = 0;
        while (!m_rdy && n < 50) begin
            step();
            n++;
        end
        if (s == 0) begin data_a = word; vld_a = 1'b1; end
        else        begin data_b = word[7:0]; vld_b = 1'b1; end
        p_sclk = m_sclk; p_sdata = m_sdata; p_csn = m_csn;
        step();
        vld_a = 1'b0;
        vld_b = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (!m_csn) low++;
            if (!m_csn && m_rdy) rdy_bad++;
            if (p_sclk && !m_sclk) begin
                falls++;
                bits = {bits[14:0], m_sdata};
                if (m_sdata !== p_sdata) edge_bad++;
            end
            if (m_sclk !== p_sclk && m_csn && p_csn) edge_bad++;
            if (m_done) dones++;
            if (!m_ldac) begin
                ldac_low++;
                if (ldac_low == 1 && !m_done) ldac_bad++;
            end
            p_sclk = m_sclk; p_sdata = m_sdata; p_csn = m_csn;
            if (m_rdy) begin
                ok = 1;
                break;
            end
            step();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[5];
        logic [15:0] bits;
        int          low, falls, dones, rdy_bad, edge_bad, ldac_low, ldac_bad, ok;
        int          viol, t, t1, t2, acc_n, high, seen_low;
        logic        rb, p_sclk;

        vecs[0] = '{0, 16'hA5C3, 16'b1010_0101_1100_0011, 136, 16, 4};
        vecs[1] = '{0, 16'hFFFF, 16'b1111_1111_1111_1111, 136, 16, 4};
        vecs[2] = '{0, 16'h8001, 16'b1000_0000_0000_0001, 136, 16, 4};
        vecs[3] = '{1, 16'h0081, 16'b0000_0000_1000_0001,  36,  8, 2};
        vecs[4] = '{1, 16'h007E, 16'b0000_0000_0111_1110,  36,  8, 2};

        // reset values and release
        sel = 0;
        repeat (3) step();
        check("rst cs_n", int'(m_csn), 1);
        check("rst sclk", int'(m_sclk), 1);
        check("rst sdata", int'(m_sdata), 0);
        check("rst da_rdy", int'(m_rdy), 0);
        check("rst da_done", int'(m_done), 0);
        check("rst ldac_n", int'(m_ldac), 1);
        rst = 1'b0;
        step();
        check("rdy after release", int'(m_rdy), 1);
        viol = 0;
        repeat (30) begin
            step();
            if (m_csn !== 1'b1 || m_sclk !== 1'b1 || m_sdata !== 1'b0 || m_rdy !== 1'b1) viol++;
        end
        check("idle hold", viol, 0);

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].s, vecs[i].word, bits, low, falls, dones, rdy_bad, edge_bad,
                      ldac_low, ldac_bad, ok);
            check($sformatf("v%0d finished", i), ok, 1);
            check($sformatf("v%0d bits", i), int'(bits), int'(vecs[i].exp_bits));
            check($sformatf("v%0d cs_n low", i), low, vecs[i].exp_low);
            check($sformatf("v%0d sclk falls", i), falls, vecs[i].exp_falls);
            check($sformatf("v%0d da_done", i), dones, 1);
            check($sformatf("v%0d rdy in frame", i), rdy_bad, 0);
            check($sformatf("v%0d sclk/sdata edges", i), edge_bad, 0);
`ifdef DA_LDAC_EN
            check($sformatf("v%0d ldac_n low", i), ldac_low, vecs[i].exp_ldac);
            check($sformatf("v%0d ldac_n align", i), ldac_bad, 0);
`else
            check($sformatf("v%0d ldac_n low", i), ldac_low, 0);
`endif
        end

        // da_vld held high across two words
        sel = 0;
        data_a = 16'hFFFF;
        vld_a = 1'b1;
        t = 0; t1 = -1; t2 = -1; acc_n = 0; high = 0; seen_low = 0;
        low = 0; dones = 0; rdy_bad = 0; falls = 0; bits = '0;
        p_sclk = m_sclk;
        while (t < 400 && !(acc_n == 2 && m_rdy)) begin
            rb = m_rdy;
            step();
            t++;
            if (rb) begin
                if (acc_n == 0) begin t1 = t; data_a = 16'h0001; end
                else begin t2 = t; vld_a = 1'b0; end
                acc_n++;
            end
            if (acc_n == 1 && seen_low != 0 && m_csn) high++;
            if (!m_csn) begin low++; seen_low = 1; end
            if (!m_csn && m_rdy) rdy_bad++;
            if (m_done) dones++;
            if (acc_n == 2 && p_sclk && !m_sclk) begin
                falls++;
                bits = {bits[14:0], m_sdata};
            end
            p_sclk = m_sclk;
        end
        vld_a = 1'b0;
        check("b2b accepts", acc_n, 2);
        check("b2b spacing", t2 - t1, 145);
        check("b2b cs_n gap>=8", int'(high >= 8), 1);
        check("b2b cs_n low", low, 272);
        check("b2b rdy in frame", rdy_bad, 0);
        check("b2b da_done", dones, 2);
        check("b2b 2nd word", int'(bits), 16'h0001);

        // abort at the 6th sclk fall
        sel = 0;
        t = 0;
        while (!m_rdy && t < 50) begin step(); t++; end
        data_a = 16'h1234;
        vld_a = 1'b1;
        step();
        vld_a = 1'b0;
        falls = 0;
        p_sclk = m_sclk;
        for (int i = 0; i < 200; i++) begin
            if (p_sclk && !m_sclk) falls++;
            if (falls == 6) break;
            p_sclk = m_sclk;
            step();
        end
        check("abort reached 6th fall", falls, 6);
        #3 rst = 1'b1;
        #1;
        check("abort cs_n", int'(m_csn), 1);
        check("abort sclk", int'(m_sclk), 1);
        check("abort sdata", int'(m_sdata), 0);
        dones = 0;
        ldac_low = 0;
        repeat (2) step();
        rst = 1'b0;
        repeat (20) begin
            if (m_done) dones++;
            if (!m_ldac) ldac_low++;
            step();
        end
        check("abort no da_done", dones, 0);
        check("abort ldac_n high", ldac_low, 0);
        check("abort back to idle", int'(m_rdy), 1);
        run_frame(0, 16'hA5C3, bits, low, falls, dones, rdy_bad, edge_bad, ldac_low, ldac_bad, ok);
        check("post-abort bits", int'(bits), 16'hA5C3);
        check("post-abort cs_n low", low, 136);
        check("post-abort da_done", dones, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
